// File: rtl/cms_axis_downsizer_pkg.sv
// Shared CMS widths and the downsizer state encoding.
// The AXI and DMA widths feed the downsizer's parameter defaults.
package cms_axis_downsizer_pkg;

    localparam int AXI_DATA_WIDTH = 1024;
    localparam int DMA_DATA_WIDTH = 64;

    typedef enum logic {
        EMPTY = 1'b0,
        SEND  = 1'b1
    } state_t;

endpackage

// File: rtl/cms_axis_downsizer.sv
// Splits one wide AXI-Stream word into RATIO narrow beats, LSB slice first,
// accepting the next word on the final beat so back-to-back words have no bubble.
module cms_axis_downsizer
    import cms_axis_downsizer_pkg::*;
#(
    parameter int IN_WIDTH  = AXI_DATA_WIDTH,
    parameter int OUT_WIDTH = DMA_DATA_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
    input  logic                 S_AXIS_tvalid,
    output logic                 S_AXIS_tready,
    input  logic                 S_AXIS_tlast,
    output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
    output logic                 M_AXIS_tvalid,
    input  logic                 M_AXIS_tready,
    output logic                 M_AXIS_tlast,
    output logic [31:0]          words_forwarded
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 2) begin : g_bad_ratio
        $error("cms_axis_downsizer: IN_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end

    state_t               r_state;
    state_t               w_stateNext;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idxNext;
    logic [IN_WIDTH-1:0]  r_held;
    logic                 r_heldLast;
    logic [31:0]          r_wordsFwd;

    logic                 w_lastBeat;
    logic                 w_inFire;
    logic                 w_outFire;
    logic                 w_wordDone;

    assign w_lastBeat = (r_idx == LAST_IDX);
    assign w_outFire  = (r_state == SEND) && M_AXIS_tready;
    assign w_wordDone = w_outFire && w_lastBeat;

    // Ready is a function of state and downstream ready only, never of S_AXIS_tvalid.
    assign S_AXIS_tready = (r_state == EMPTY) || (w_lastBeat && M_AXIS_tready);
    assign w_inFire      = S_AXIS_tvalid && S_AXIS_tready;

    always_comb begin
        w_stateNext = r_state;
        w_idxNext   = r_idx;
        case (r_state)
            EMPTY: begin
                if (w_inFire) begin
                    w_stateNext = SEND;
                    w_idxNext   = '0;
                end
            end
            SEND: begin
                if (w_outFire) begin
                    if (w_lastBeat) begin
                        w_stateNext = w_inFire ? SEND : EMPTY;
                        w_idxNext   = '0;
                    end else begin
                        w_idxNext = r_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext = EMPTY;
                w_idxNext   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= EMPTY;
            r_idx      <= '0;
            r_heldLast <= 1'b0;
            r_wordsFwd <= '0;
        end else begin
            r_state <= w_stateNext;
            r_idx   <= w_idxNext;
            if (w_inFire) begin
                r_heldLast <= S_AXIS_tlast;
            end
            if (w_wordDone) begin
                r_wordsFwd <= r_wordsFwd + 32'd1;
            end
        end
    end

    // Holding data is never cleared; it is only visible while a word is held.
    always_ff @(posedge clk) begin
        if (w_inFire) begin
            r_held <= S_AXIS_tdata;
        end
    end

    assign M_AXIS_tvalid   = (r_state == SEND);
    assign M_AXIS_tdata    = r_held[r_idx*OUT_WIDTH +: OUT_WIDTH];
    assign M_AXIS_tlast    = (r_state == SEND) && r_heldLast && w_lastBeat;
    assign words_forwarded = r_wordsFwd;

endmodule

// File: tb/tb_cms_axis_downsizer.sv
// Directed self-checking bench for cms_axis_downsizer at the default 1024->64 widths.
// A per-cycle vector table covers the basic word; hand sequences cover stalls, back-to-back, reset and wrap.
module tb_cms_axis_downsizer;
    import cms_axis_downsizer_pkg::*;

    localparam int IW    = AXI_DATA_WIDTH;
    localparam int OW    = DMA_DATA_WIDTH;
    localparam int RATIO = IW / OW;

    logic          clk = 1'b0;
    logic          rst;
    logic [IW-1:0] sData;
    logic          sValid;
    logic          sReady;
    logic          sLast;
    logic [OW-1:0] mData;
    logic          mValid;
    logic          mReady;
    logic          mLast;
    logic [31:0]   wordsFwd;

    int nVectors     = 0;
    int nMiscompares = 0;

    typedef struct {
        logic        sValid;
        logic [63:0] sBase;
        logic        sLast;
        logic        mReady;
        logic        expValid;
        logic        checkData;
        logic [63:0] expData;
        logic        expLast;
        logic        expSReady;
    } vec_t;

    vec_t vecs [RATIO + 2];

    cms_axis_downsizer dut (
        .clk             (clk),
        .rst             (rst),
        .S_AXIS_tdata    (sData),
        .S_AXIS_tvalid   (sValid),
        .S_AXIS_tready   (sReady),
        .S_AXIS_tlast    (sLast),
        .M_AXIS_tdata    (mData),
        .M_AXIS_tvalid   (mValid),
        .M_AXIS_tready   (mReady),
        .M_AXIS_tlast    (mLast),
        .words_forwarded (wordsFwd)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mkWord(input logic [63:0] base);
        logic [IW-1:0] w;
        w = '0;
        for (int k = 0; k < RATIO; k++) begin
            w[k*OW +: OW] = base + 64'(k);
        end
        return w;
    endfunction

    task automatic applyStimulus(input logic v, input logic [IW-1:0] d, input logic l, input logic mr);
        @(negedge clk);
        sValid = v;
        sData  = d;
        sLast  = l;
        mReady = mr;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic checkBeat(input string tag, input logic ev, input logic cd, input logic [63:0] ed,
                             input logic el, input logic er);
        checkOutput({tag, " tvalid"}, 64'(mValid), 64'(ev));
        if (cd) begin
            checkOutput({tag, " tdata"}, 64'(mData), ed);
        end
        checkOutput({tag, " tlast"}, 64'(mLast), 64'(el));
        checkOutput({tag, " s_tready"}, 64'(sReady), 64'(er));
    endtask

    // Offer one word with downstream always ready, then check all RATIO beats.
    task automatic runWord(input string tag, input logic [63:0] base, input logic l);
        applyStimulus(1'b1, mkWord(base), l, 1'b1);
        checkBeat({tag, " accept"}, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        for (int b = 0; b < RATIO; b++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkBeat($sformatf("%s beat%0d", tag, b), 1'b1, 1'b1, base + 64'(b),
                      l && (b == RATIO - 1), (b == RATIO - 1));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkBeat({tag, " idle"}, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        int beat;
        int cyc;

        rst    = 1'b1;
        sValid = 1'b0;
        sData  = '0;
        sLast  = 1'b0;
        mReady = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkBeat("reset", 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("reset words_forwarded", 64'(wordsFwd), 64'd0);

        // Single word, slice k = k, tlast set, downstream always ready.
        vecs[0] = '{1'b1, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1};
        for (int k = 1; k <= RATIO; k++) begin
            vecs[k] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 64'(k - 1), (k == RATIO), (k == RATIO)};
        end
        vecs[RATIO + 1] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1};
        for (int i = 0; i < RATIO + 2; i++) begin
            applyStimulus(vecs[i].sValid, mkWord(vecs[i].sBase), vecs[i].sLast, vecs[i].mReady);
            checkBeat($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].checkData, vecs[i].expData,
                      vecs[i].expLast, vecs[i].expSReady);
        end
        checkOutput("single words_forwarded", 64'(wordsFwd), 64'd1);

        // Downstream ready toggling 1,0,0,1: each beat must hold through stalls.
        pat = 4'b1001;
        applyStimulus(1'b1, mkWord(64'h100), 1'b1, 1'b1);
        checkBeat("stall accept", 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        beat = 0;
        cyc  = 0;
        while (beat < RATIO && cyc < 100) begin
            applyStimulus(1'b0, '0, 1'b0, pat[cyc % 4]);
            checkBeat($sformatf("stall cyc%0d", cyc), 1'b1, 1'b1, 64'h100 + 64'(beat),
                      (beat == RATIO - 1), (beat == RATIO - 1) && pat[cyc % 4]);
            if (pat[cyc % 4]) beat++;
            cyc++;
        end
        checkOutput("stall beats emitted", 64'(beat), 64'(RATIO));
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkBeat("stall idle", 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("stall words_forwarded", 64'(wordsFwd), 64'd2);

        // Two words back-to-back: first without tlast, second with it.
        applyStimulus(1'b1, mkWord(64'h200), 1'b0, 1'b1);
        checkBeat("b2b accept", 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        for (int b = 0; b < 2 * RATIO; b++) begin
            applyStimulus(b < RATIO, mkWord(64'h300), b < RATIO, 1'b1);
            checkBeat($sformatf("b2b beat%0d", b), 1'b1, 1'b1,
                      (b < RATIO) ? 64'h200 + 64'(b) : 64'h300 + 64'(b - RATIO),
                      (b == 2 * RATIO - 1), (b == RATIO - 1) || (b == 2 * RATIO - 1));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkBeat("b2b idle", 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("b2b words_forwarded", 64'(wordsFwd), 64'd4);

        // Reset after beat 5 is accepted discards the rest of the word.
        applyStimulus(1'b1, mkWord(64'h400), 1'b1, 1'b1);
        for (int b = 0; b < 6; b++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkBeat($sformatf("midrst beat%0d", b), 1'b1, 1'b1, 64'h400 + 64'(b), 1'b0, 1'b0);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkBeat("midrst after", 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
        checkOutput("midrst words_forwarded", 64'(wordsFwd), 64'd0);
        runWord("restart", 64'h500, 1'b1);
        checkOutput("restart words_forwarded", 64'(wordsFwd), 64'd1);

        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.r_wordsFwd = 32'hFFFF_FFFF;
        #1;
        release dut.r_wordsFwd;
        #1;
        checkOutput("wrap preload", 64'(wordsFwd), 64'hFFFF_FFFF);
        runWord("wrap", 64'h600, 1'b0);
        checkOutput("wrap words_forwarded", 64'(wordsFwd), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
